// File: rtl/frame_loader.sv
// Sample-to-frame packer and CNN run sequencer for the bearing classifier.
// Optional TWOS_TO_SM_EN: convert two's-complement samples to sign-magnitude on write.
module frame_loader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAME_LEN  = 1024,
  parameter int unsigned CLASS_W    = 4,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DATA_WIDTH-1:0]           s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  output logic [FRAME_LEN*DATA_WIDTH-1:0] frame_data,
  output logic                            frame_valid,
  input  logic                            cnn_done,
  input  logic [CLASS_W-1:0]              cnn_class,
  output logic [CLASS_W-1:0]              class_out,
  output logic                            class_valid,
  output logic                            timeout_err
);

  localparam int unsigned IdxW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned WdW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StFill, StRun, StCapture, StFlush} state_e;

  state_e                          state_q, state_d;
  logic [IdxW-1:0]                 wr_idx_q, wr_idx_d;
  logic [FRAME_LEN*DATA_WIDTH-1:0] frame_data_q, frame_data_d;
  logic [CLASS_W-1:0]              class_out_q, class_out_d;
  logic                            timeout_err_q, timeout_err_d;
  logic [WdW-1:0]                  wd_q, wd_d;
  logic [DATA_WIDTH-1:0]           sample;
  logic                            timeout_hit;
  int unsigned                     base;

`ifdef TWOS_TO_SM_EN
  logic [DATA_WIDTH-1:0] mag;
  always_comb begin
    mag    = -s_data;
    sample = s_data;
    // The most negative value has no sign-magnitude twin; clamp to the largest negative.
    if (s_data == {1'b1, {(DATA_WIDTH-1){1'b0}}}) begin
      sample = '1;
    end else if (s_data[DATA_WIDTH-1]) begin
      sample = {1'b1, mag[DATA_WIDTH-2:0]};
    end
  end
`else
  assign sample = s_data;
`endif

  assign timeout_hit = (TIMEOUT != 0) && (32'(wd_q) == TIMEOUT - 1);

  always_comb begin
    state_d       = state_q;
    wr_idx_d      = wr_idx_q;
    frame_data_d  = frame_data_q;
    class_out_d   = class_out_q;
    timeout_err_d = timeout_err_q;
    wd_d          = '0;
    base          = 32'(wr_idx_q) * DATA_WIDTH;
    unique case (state_q)
      StFill: begin
        if (s_valid) begin
          frame_data_d[base +: DATA_WIDTH] = sample;
          if (32'(wr_idx_q) == FRAME_LEN - 1) begin
            wr_idx_d = '0;
            state_d  = StRun;
          end else begin
            wr_idx_d = wr_idx_q + IdxW'(1);
          end
        end
      end
      StRun: begin
        wd_d = wd_q + WdW'(1);
        // A result arriving on the abort cycle still counts.
        if (cnn_done) begin
          class_out_d = cnn_class;
          state_d     = StCapture;
        end else if (timeout_hit) begin
          timeout_err_d = 1'b1;
          state_d       = StFlush;
        end
      end
      StCapture: state_d = StFlush;
      StFlush:   state_d = StFill;
      default:   state_d = StFill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StFill;
      wr_idx_q      <= '0;
      frame_data_q  <= '0;
      class_out_q   <= '0;
      timeout_err_q <= 1'b0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      wr_idx_q      <= wr_idx_d;
      frame_data_q  <= frame_data_d;
      class_out_q   <= class_out_d;
      timeout_err_q <= timeout_err_d;
      wd_q          <= wd_d;
    end
  end

  assign s_ready     = (state_q == StFill);
  assign frame_valid = (state_q == StRun) || (state_q == StCapture);
  assign class_valid = (state_q == StCapture);
  assign frame_data  = frame_data_q;
  assign class_out   = class_out_q;
  assign timeout_err = timeout_err_q;

endmodule
